pwm_phase_bank: RTL and testbench
=================================

// Module: pwm_phase_bank
// PURPOSE
//   Multi-channel PWM generator for the photonic-switch drivers, running on one core clock.
//   NCH channels share one frame counter. Each channel has its own duty and phase offset.
//   Emits level outputs plus one-cycle set/reset edge pulses for the switch latches.
//   Period, duty, phase and prescale are double-buffered: new values take effect at a frame boundary, never mid-frame.
// PARAMETERS
//   NCH  4  number of PWM channels
//   CW   7  frame counter / duty / phase width (bits)
//   PW   8  prescaler width (bits)
// PORTS
//   clk          in   1       core clock, rising edge
//   reset_n      in   1       asynchronous active-low reset
//   en           in   1       count enable; low freezes prescaler, counter and outputs
//   prescale     in   PW      frame counter advances every prescale+1 clocks
//   period       in   CW      frame length = period+1 counts
//   duty_flat    in   NCH*CW  channel i duty = [i*CW +: CW], in counts
//   phase_flat   in   NCH*CW  channel i phase = [i*CW +: CW], in counts
//   load         in   1       1-cycle strobe: capture all config inputs into the pending set
//   busy         out  1       pending set captured, not yet applied
//   load_ack     out  1       1-cycle pulse in the cycle the pending set becomes active
//   tick         out  1       1-cycle pulse, prescaler terminal count (gated by en)
//   cnt          out  CW      frame counter
//   pwm          out  NCH     channel levels
//   set_pulse    out  NCH     1-cycle pulse on the rising edge of pwm[i]
//   reset_pulse  out  NCH     1-cycle pulse on the falling edge of pwm[i]
// BEHAVIOUR
//   - reset_n low: all outputs 0 immediately. Prescaler, cnt, pending and active config regs are 0; busy=0.
//   - Prescaler: pc counts 0..prescale_act. tick=1 when en && pc==prescale_act, then pc<=0.
//     prescale_act=0 gives tick every cycle while en=1.
//   - Frame counter: on tick, cnt<=(cnt==period_act)?0:cnt+1. The wrap tick is the frame boundary.
//   - Active config after reset has period 0, so every tick is a boundary.
//   - load: pending<=inputs, busy<=1. A load while busy overwrites pending; only the last load applies.
//   - Apply: at a boundary tick with busy=1, active<=pending, cnt<=0, pc<=0, busy<=0, load_ack=1 for that cycle.
//     If load and a boundary coincide, the old pending set applies. The new capture stays pending and busy stays 1.
//   - Channel level (combinational term, CW+1-bit arithmetic):
//     rel = (cnt>=ph) ? cnt-ph : cnt+period_act+1-ph; want_i = (rel < duty_i).
//   - Phase wraps across the boundary. duty=0 gives constant low. duty>period gives constant high.
//   - Phase > period_act: channel forced low.
//   - pwm[i] is registered from want_i: pwm lags cnt by exactly one clock.
//   - set_pulse[i]=1 in the cycle pwm[i] goes 0->1; reset_pulse[i]=1 in the cycle it goes 1->0.
//     Both are registered alongside pwm, never both high, and never asserted when pwm does not change.
//   - en low: pc, cnt, pwm hold; tick, set/reset pulses low. load is still captured.
//     No apply occurs while en is low.
//   - Reset mid-frame: outputs drop at once. No reset_pulse is emitted for a channel forced low by reset.
// TESTING (NCH=4, CW=7)
//   1. load prescale=0, period=9, duty0=3, phase0=0, en=1 -> load_ack at next tick; then pwm0 high for cnt 0..2 (+1 clk lag), period 10 clks; set_pulse0/reset_pulse0 once per 10 clks.
//   2. period=9, duty1=4, phase1=8 -> pwm1 high for cnt 8,9,0,1 across the wrap, no glitch at boundary.
//   3. duty2=0 and duty3=10 with period=9 -> pwm2 stuck 0, pwm3 stuck 1 after first frame, no further pulses on ch2/ch3.
//   4. prescale=3, period=9 -> tick every 4 clks, frame = 40 clks, duty0=3 gives 12 clks high.
//   5. load at cnt=4 mid-frame, second load at cnt=6 with duty0=5 -> busy=1 until wrap; load_ack at wrap; duty0=5 in effect, first value never seen.
//   6. en low at cnt=5 for 20 clks then high -> cnt/pwm frozen, no pulses; resumes at cnt=5. reset_n low mid-frame -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/pwm_phase_bank_if.sv
// Configuration, strobe and PWM output bundle for pwm_phase_bank.
interface pwm_phase_bank_if #(
   parameter int unsigned NCH = 4,
   parameter int unsigned CW  = 7,
   parameter int unsigned PW  = 8
);
   logic                en;
   logic [PW-1:0]       prescale;
   logic [CW-1:0]       period;
   logic [NCH*CW-1:0]   duty_flat;
   logic [NCH*CW-1:0]   phase_flat;
   logic                load;
   logic                busy;
   logic                load_ack;
   logic                tick;
   logic [CW-1:0]       cnt;
   logic [NCH-1:0]      pwm;
   logic [NCH-1:0]      set_pulse;
   logic [NCH-1:0]      reset_pulse;

   // Controller side: drives config and strobes, observes status and PWM.
   modport master (
      output en, prescale, period, duty_flat, phase_flat, load,
      input  busy, load_ack, tick, cnt, pwm, set_pulse, reset_pulse
   );

   // Generator side.
   modport slave (
      input  en, prescale, period, duty_flat, phase_flat, load,
      output busy, load_ack, tick, cnt, pwm, set_pulse, reset_pulse
   );
endinterface

// File: rtl/pwm_phase_bank.sv
// Multi-channel phase-offset PWM bank with double-buffered configuration.
// Config captured by load is applied only at a frame-wrap tick.
module pwm_phase_bank #(
   parameter int unsigned NCH = 4,
   parameter int unsigned CW  = 7,
   parameter int unsigned PW  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   pwm_phase_bank_if.slave  bus
);
   localparam int unsigned RW = CW + 1;
   localparam int unsigned FW = NCH * CW;

   logic [PW-1:0]  pc;
   logic [CW-1:0]  cnt;
   logic           busy;
   logic [PW-1:0]  pend_prescale, act_prescale;
   logic [CW-1:0]  pend_period,   act_period;
   logic [FW-1:0]  pend_duty,     act_duty;
   logic [FW-1:0]  pend_phase,    act_phase;
   logic [NCH-1:0] pwm_q, set_q, rst_q;
   logic           tick_q, ack_q;

   logic           tc, adv, boundary, apply;
   logic [NCH-1:0] want;

   // Prescaler terminal count, counter advance, frame boundary and config swap.
   assign tc       = (pc == act_prescale);
   assign adv      = bus.en & tc;
   assign boundary = adv & (cnt == act_period);
   assign apply    = boundary & busy;

   // Per-channel level: position within the frame relative to the phase offset.
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [CW-1:0] ph, du;
      logic [RW-1:0] rel;
      assign ph      = act_phase[g*CW +: CW];
      assign du      = act_duty[g*CW +: CW];
      assign rel     = (cnt >= ph) ? RW'(cnt) - RW'(ph)
                                   : RW'(cnt) + RW'(act_period) + RW'(1) - RW'(ph);
      assign want[g] = (ph <= act_period) && (rel < RW'(du));
   end

   // Prescaler and frame counter; both restart when a new config is applied.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc  <= '0;
         cnt <= '0;
      end else if (apply) begin
         pc  <= '0;
         cnt <= '0;
      end else if (bus.en) begin
         pc <= tc ? '0 : pc + PW'(1);
         if (tc) cnt <= (cnt == act_period) ? '0 : cnt + CW'(1);
      end
   end

   // Pending/active config double buffer; a coincident load stays pending.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy          <= 1'b0;
         pend_prescale <= '0;
         pend_period   <= '0;
         pend_duty     <= '0;
         pend_phase    <= '0;
         act_prescale  <= '0;
         act_period    <= '0;
         act_duty      <= '0;
         act_phase     <= '0;
      end else begin
         if (apply) begin
            act_prescale <= pend_prescale;
            act_period   <= pend_period;
            act_duty     <= pend_duty;
            act_phase    <= pend_phase;
         end
         if (bus.load) begin
            pend_prescale <= bus.prescale;
            pend_period   <= bus.period;
            pend_duty     <= bus.duty_flat;
            pend_phase    <= bus.phase_flat;
            busy          <= 1'b1;
         end else if (apply) begin
            busy <= 1'b0;
         end
      end
   end

   // Registered levels, edge pulses and status strobes; all frozen/quiet while en is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_q  <= '0;
         set_q  <= '0;
         rst_q  <= '0;
         tick_q <= 1'b0;
         ack_q  <= 1'b0;
      end else begin
         tick_q <= adv;
         ack_q  <= apply;
         if (bus.en) begin
            pwm_q <= want;
            set_q <= want & ~pwm_q;
            rst_q <= ~want & pwm_q;
         end else begin
            set_q <= '0;
            rst_q <= '0;
         end
      end
   end

   assign bus.busy        = busy;
   assign bus.load_ack    = ack_q;
   assign bus.tick        = tick_q;
   assign bus.cnt         = cnt;
   assign bus.pwm         = pwm_q;
   assign bus.set_pulse   = set_q;
   assign bus.reset_pulse = rst_q;
endmodule

// File: tb/tb_pwm_phase_bank.sv
// Directed and randomized bench for pwm_phase_bank against a frame-level reference model.
module tb_pwm_phase_bank;
   localparam int unsigned NCH = 4;
   localparam int unsigned CW  = 7;
   localparam int unsigned PW  = 8;

   logic clk;
   logic reset_n;
   logic c_en, c_load;
   int   c_pre, c_per;
   int   c_duty[NCH];
   int   c_phase[NCH];

   int n_pass, n_total, n_fail;

   pwm_phase_bank_if #(.NCH(NCH), .CW(CW), .PW(PW)) bus ();

   pwm_phase_bank #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   assign bus.en       = c_en;
   assign bus.load     = c_load;
   assign bus.prescale = PW'(c_pre);
   assign bus.period   = CW'(c_per);
   always_comb begin
      bus.duty_flat  = '0;
      bus.phase_flat = '0;
      for (int i = 0; i < NCH; i++) begin
         bus.duty_flat[i*CW +: CW]  = CW'(c_duty[i]);
         bus.phase_flat[i*CW +: CW] = CW'(c_phase[i]);
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model state.
   int m_pc, m_cnt, m_busy;
   int a_pre, a_per, a_duty[NCH], a_ph[NCH];
   int p_pre, p_per, p_duty[NCH], p_ph[NCH];
   int m_pwm[NCH];
   int e_tick, e_ack, e_set[NCH], e_rst[NCH];

   // Observed window statistics.
   int w_hi[NCH], w_set[NCH], w_rst[NCH], w_tick;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_cnt = 0; m_busy = 0;
      a_pre = 0; a_per = 0; p_pre = 0; p_per = 0;
      e_tick = 0; e_ack = 0;
      for (int i = 0; i < NCH; i++) begin
         a_duty[i] = 0; a_ph[i] = 0; p_duty[i] = 0; p_ph[i] = 0;
         m_pwm[i] = 0; e_set[i] = 0; e_rst[i] = 0;
      end
   endtask

   // Channel is high while its distance past the phase point, modulo frame length, is below duty.
   function automatic int want_of(input int ch);
      int rel;
      if (a_ph[ch] > a_per) return 0;
      rel = (m_cnt - a_ph[ch] + a_per + 1) % (a_per + 1);
      return (rel < a_duty[ch]) ? 1 : 0;
   endfunction

   // One clock: advance the model with the inputs present at this edge, then compare.
   task automatic cyc();
      int fire, wrap, swap, w, ep, es, er;
      @(posedge clk);
      fire = (c_en && m_pc == a_pre) ? 1 : 0;
      wrap = (fire && m_cnt == a_per) ? 1 : 0;
      swap = (wrap && m_busy) ? 1 : 0;
      for (int i = 0; i < NCH; i++) begin
         w = want_of(i);
         e_set[i] = (c_en && w == 1 && m_pwm[i] == 0) ? 1 : 0;
         e_rst[i] = (c_en && w == 0 && m_pwm[i] == 1) ? 1 : 0;
         if (c_en) m_pwm[i] = w;
      end
      e_tick = fire;
      e_ack  = swap;
      if (c_en) m_pc = fire ? 0 : m_pc + 1;
      if (fire) m_cnt = wrap ? 0 : m_cnt + 1;
      if (swap) begin
         m_pc = 0; m_cnt = 0;
         a_pre = p_pre; a_per = p_per;
         for (int i = 0; i < NCH; i++) begin a_duty[i] = p_duty[i]; a_ph[i] = p_ph[i]; end
      end
      if (c_load) begin
         p_pre = c_pre; p_per = c_per;
         for (int i = 0; i < NCH; i++) begin p_duty[i] = c_duty[i]; p_ph[i] = c_phase[i]; end
         m_busy = 1;
      end else if (swap) begin
         m_busy = 0;
      end
      #1;
      ep = 0; es = 0; er = 0;
      for (int i = 0; i < NCH; i++) begin
         ep += m_pwm[i] << i;
         es += e_set[i] << i;
         er += e_rst[i] << i;
      end
      chk("cnt", 32'(bus.cnt), 32'(m_cnt));
      chk("pwm", 32'(bus.pwm), 32'(ep));
      chk("set_pulse", 32'(bus.set_pulse), 32'(es));
      chk("reset_pulse", 32'(bus.reset_pulse), 32'(er));
      chk("tick", 32'(bus.tick), 32'(e_tick));
      chk("load_ack", 32'(bus.load_ack), 32'(e_ack));
      chk("busy", 32'(bus.busy), 32'(m_busy));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_cnt"}, 32'(bus.cnt), 0);
      chk({tag, "_pwm"}, 32'(bus.pwm), 0);
      chk({tag, "_set"}, 32'(bus.set_pulse), 0);
      chk({tag, "_rst"}, 32'(bus.reset_pulse), 0);
      chk({tag, "_tick"}, 32'(bus.tick), 0);
      chk({tag, "_ack"}, 32'(bus.load_ack), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
   endtask

   task automatic set_cfg(input int pre, input int per,
                          input int d0, input int d1, input int d2, input int d3,
                          input int h0, input int h1, input int h2, input int h3);
      c_pre = pre; c_per = per;
      c_duty[0] = d0; c_duty[1] = d1; c_duty[2] = d2; c_duty[3] = d3;
      c_phase[0] = h0; c_phase[1] = h1; c_phase[2] = h2; c_phase[3] = h3;
   endtask

   task automatic do_load();
      c_load = 1'b1;
      cyc();
      c_load = 1'b0;
   endtask

   task automatic wait_ack(input string tag, input int bound);
      int got;
      got = 0;
      for (int k = 0; k < bound; k++) begin
         cyc();
         if (bus.load_ack) begin got = 1; break; end
      end
      chk(tag, 32'(got), 1);
   endtask

   task automatic wait_cnt(input string tag, input int v, input int bound);
      for (int k = 0; k < bound; k++) begin
         cyc();
         if (bus.cnt == CW'(v)) break;
      end
      chk(tag, 32'(bus.cnt), 32'(v));
   endtask

   task automatic count_win(input int n);
      w_tick = 0;
      for (int i = 0; i < NCH; i++) begin w_hi[i] = 0; w_set[i] = 0; w_rst[i] = 0; end
      repeat (n) begin
         cyc();
         w_tick += int'(bus.tick);
         for (int i = 0; i < NCH; i++) begin
            w_hi[i]  += int'(bus.pwm[i]);
            w_set[i] += int'(bus.set_pulse[i]);
            w_rst[i] += int'(bus.reset_pulse[i]);
         end
      end
   endtask

   task automatic rand_cfg();
      c_pre = $urandom_range(0, 3);
      c_per = $urandom_range(0, 20);
      for (int i = 0; i < NCH; i++) begin
         c_duty[i]  = $urandom_range(0, c_per + 2);
         c_phase[i] = $urandom_range(0, c_per + 2);
      end
   endtask

   initial begin
      n_pass = 0; n_total = 0; n_fail = 0;
      c_en = 1'b0; c_load = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #2 check_zero("rst_init");
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      cyc();

      // Basic frame: period 10, duty 3 on channel 0.
      set_cfg(0, 9, 3, 0, 0, 0, 0, 0, 0, 0);
      c_en = 1'b1;
      do_load();
      wait_ack("t1_ack", 40);
      count_win(10);
      chk("t1_hi0", 32'(w_hi[0]), 3);
      chk("t1_set0", 32'(w_set[0]), 1);
      chk("t1_rst0", 32'(w_rst[0]), 1);

      // Phase wrap on ch1, constant low ch2, constant high ch3.
      set_cfg(0, 9, 3, 4, 0, 10, 0, 8, 0, 0);
      do_load();
      wait_ack("t2_ack", 40);
      count_win(10);
      count_win(10);
      chk("t2_hi1", 32'(w_hi[1]), 4);
      chk("t2_set1", 32'(w_set[1]), 1);
      chk("t2_rst1", 32'(w_rst[1]), 1);
      chk("t3_hi2", 32'(w_hi[2]), 0);
      chk("t3_pulse2", 32'(w_set[2] + w_rst[2]), 0);
      chk("t3_hi3", 32'(w_hi[3]), 10);
      chk("t3_pulse3", 32'(w_set[3] + w_rst[3]), 0);

      // Prescale 3: 40-clock frames, 12 clocks high.
      set_cfg(3, 9, 3, 4, 0, 10, 0, 8, 0, 0);
      do_load();
      wait_ack("t4_ack", 40);
      count_win(40);
      count_win(40);
      chk("t4_hi0", 32'(w_hi[0]), 12);
      chk("t4_set0", 32'(w_set[0]), 1);
      chk("t4_ticks", 32'(w_tick), 10);

      // Mid-frame reloads: only the last one takes effect.
      set_cfg(0, 9, 3, 4, 0, 10, 0, 8, 0, 0);
      do_load();
      wait_ack("t5_ack0", 60);
      wait_cnt("t5_cnt4", 4, 20);
      c_duty[0] = 7;
      do_load();
      wait_cnt("t5_cnt6", 6, 20);
      c_duty[0] = 5;
      do_load();
      chk("t5_busy", 32'(bus.busy), 1);
      wait_ack("t5_ack1", 20);
      count_win(10);
      chk("t5_hi0", 32'(w_hi[0]), 5);

      // Enable low freezes everything.
      wait_cnt("t6_cnt5", 5, 30);
      c_en = 1'b0;
      count_win(20);
      chk("t6_frozen_cnt", 32'(bus.cnt), 5);
      chk("t6_pulses", 32'(w_set[0] + w_rst[0] + w_set[1] + w_rst[1]), 0);
      chk("t6_ticks", 32'(w_tick), 0);
      c_en = 1'b1;
      cyc();
      chk("t6_resume", 32'(bus.cnt), 6);

      // Asynchronous reset mid-frame.
      repeat (2) cyc();
      chk("pre_rst_pwm3", 32'(bus.pwm[3]), 1);
      #2 reset_n = 1'b0;
      #1 check_zero("rst_mid");
      model_reset();
      @(negedge clk) reset_n = 1'b1;
      cyc();

      // Randomized configs, loads and enable gaps.
      for (int it = 0; it < 25; it++) begin
         rand_cfg();
         c_en = 1'b1;
         do_load();
         repeat ($urandom_range(40, 120)) begin
            c_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) begin
               rand_cfg();
               c_load = 1'b1;
            end else begin
               c_load = 1'b0;
            end
            cyc();
         end
         c_load = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
